vga_frame_capture: RTL and testbench
====================================

Name: vga_frame_capture

Overview:
- Synthesizable VGA stream capture unit; a parametrised successor of the behavioural per-pixel frame grabber used around DebugScreenCore.
- Taps hsync/vsync/R/G/B of any VGA source, locks to frame timing and checks sync periods.
- Emits active-area pixels with x/y coordinates over a valid/ready stream, expanded to 8 bits per colour; counts frames and stops after a programmable number of frames.

Parameters:
- CW, 4, input colour width per channel (1..8).
- H_TOTAL, 800, clocks per line.
- V_TOTAL, 525, lines per frame.
- H_START, 144, clock index (from hsync leading edge) of first active pixel.
- V_START, 35, line index (from vsync leading edge) of first active line.
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- FRAMES, 7, frames to capture before stopping; 0 = unlimited.
- SYNC_POL, 0, sync active level (0 = active-low).

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- en  in  1  capture enable
- hsync  in  1  source hsync
- vsync  in  1  source vsync
- R, G, B  in  CW each  source colour
- pix_valid  out  1  pixel available
- pix_ready  in  1  consumer accepts pixel
- pix_data  out  24  {R8,G8,B8}; each channel is its CW bits replicated and truncated to 8 (MSB-aligned)
- pix_x  out  $clog2(H_ACTIVE)  active-area column
- pix_y  out  $clog2(V_ACTIVE)  active-area row
- pix_last  out  1  marks pixel (H_ACTIVE-1, V_ACTIVE-1)
- frame_done  out  1  one-cycle pulse when last pixel is loaded into the output slot
- frame_cnt  out  16  completed frames, saturating
- capture_done  out  1  FRAMES reached; sticky
- sync_err  out  1  sticky timing error
- ovf  out  1  sticky overflow: pixel dropped, slot occupied

Behaviour:
- Reset: all outputs 0; FSM = WAIT_VSYNC; counters 0.
- Leading edge = input becomes active (per SYNC_POL) vs its 1-cycle-delayed copy.
- h_cnt: 0 on the hsync leading-edge sample, otherwise +1. It does not wrap; saturates at H_TOTAL-1 only when sync is missing.
- v_cnt: 0 on the vsync leading-edge sample, +1 on each hsync leading edge. If both edges occur in the same cycle, vsync wins (v_cnt=0).
- Active pixel: H_START <= h_cnt < H_START+H_ACTIVE and V_START <= v_cnt < V_START+V_ACTIVE. x = h_cnt-H_START, y = v_cnt-V_START. RGB sampled in the same cycle.
- FSM states:
  - WAIT_VSYNC → CAPTURE on vsync leading edge with en=1.
  - CAPTURE → WAIT_VSYNC if en=0 (frame abandoned, not counted) or on sync error.
  - CAPTURE → DONE when frame_cnt reaches FRAMES (FRAMES≠0).
  - DONE is held until reset.
- Sync error (CAPTURE only): hsync leading edge with h_cnt≠H_TOTAL-1, or vsync leading edge with v_cnt≠V_TOTAL-1 → sync_err=1, FSM to WAIT_VSYNC. The first edge after lock is exempt.
- Output slot: one register; latency 1 clk from RGB sample to pix_valid.
  - pix_valid stays high with data stable until pix_valid&pix_ready.
  - A new pixel arriving while the slot is full and not accepted in the same cycle is dropped and sets ovf.
  - Accept and load in the same cycle is allowed (throughput 1/clk).
- frame_done pulses and frame_cnt increments when the last pixel is loaded, even if it is later stalled. A dropped last pixel still completes the frame; ovf is set.
- Synchronous reset mid-frame clears the slot immediately; the block relocks on the next vsync.

Optional Feature:
- VFC_CRC_EN defined: extra output frame_crc[15:0], CRC-16-CCITT (poly 0x1021, init 0xFFFF) over pix_data of every loaded pixel in the frame. Updated in the same cycle as frame_done and held until the next frame_done. The CRC is reinitialised at each frame start.
- Undefined: port absent, no CRC logic.

Decomposition:
- Package vfc_pkg: FSM enum vfc_state_t (WAIT_VSYNC, CAPTURE, DONE), rgb888_t packed struct, CRC16 constants, function expand_col(CW→8).
- Sub-module vfc_sync_det: polarity adjust, delay register, leading-edge pulses for hsync and vsync.

Test Plan:
- Small timing (H_TOTAL=20, V_TOTAL=12, H_START=4, V_START=2, H_ACTIVE=8, V_ACTIVE=6, FRAMES=2), pix_ready=1, R=x[3:0] → 48 pixels/frame; pix_last at (7,5); frame_cnt=2; capture_done=1; no further pix_valid.
- CW=4, R=4'hA, G=4'h5, B=4'hF → pix_data=24'hAA55FF.
- pix_ready held 0 for 3 cycles mid-line → first pixel held stable, next 3 dropped, ovf=1.
- Short line (hsync edge at h_cnt=15) in CAPTURE → sync_err=1, FSM WAIT_VSYNC, frame_cnt unchanged.
- en dropped mid-frame then raised → no pixels until next vsync edge; frame_cnt counts only full frames.
- resetn low at pixel (3,2) → all outputs 0 next clk; capture restarts at the following frame from (0,0).

Source files
------------

// File: rtl/vfc_pkg.sv
// vfc_pkg: shared types, CRC constants and helpers for the VGA frame capture unit
package vfc_pkg;

    typedef enum logic [1:0] {
        WAIT_VSYNC,
        CAPTURE,
        DONE
    } vfc_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb888_t;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // MSB-aligned widening: the cw source bits are repeated down the byte
    function automatic logic [7:0] expand_col(input logic [7:0] c, input int cw);
        logic [7:0] e;
        e = '0;
        for (int i = 0; i < 8; i++)
            e[3'(7 - i)] = c[3'(cw - 1 - (i % cw))];
        return e;
    endfunction

    // CRC-16-CCITT over one 24-bit pixel, MSB first
    function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [23:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc;
        for (int i = 23; i >= 0; i--) begin
            fb = c[15] ^ d[5'(i)];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
        end
        return c;
    endfunction

endpackage

// File: rtl/vfc_sync_det.sv
// vfc_sync_det: normalises sync polarity and flags hsync/vsync leading edges
module vfc_sync_det #(
    parameter int SYNC_POL = 0
) (
    input  logic clk,
    input  logic resetn,
    input  logic hsync_i,
    input  logic vsync_i,
    output logic hs_lead_o,
    output logic vs_lead_o
);

    localparam logic POL = 1'(SYNC_POL);

    logic hs_act, vs_act;
    logic hs_q, vs_q;

    assign hs_act = (hsync_i == POL);
    assign vs_act = (vsync_i == POL);

    // one-cycle delayed copy of the active-high sync levels
    always_ff @(posedge clk) begin
        if (!resetn) begin
            hs_q <= 1'b0;
            vs_q <= 1'b0;
        end else begin
            hs_q <= hs_act;
            vs_q <= vs_act;
        end
    end

    assign hs_lead_o = hs_act & ~hs_q;
    assign vs_lead_o = vs_act & ~vs_q;

endmodule

// File: rtl/vga_frame_capture.sv
// vga_frame_capture: locks to VGA timing, streams active pixels with x/y and counts frames
// Optional: define VFC_CRC_EN to add frame_crc (CRC-16-CCITT of every loaded pixel per frame).
module vga_frame_capture
    import vfc_pkg::*;
#(
    parameter int CW       = 4,
    parameter int H_TOTAL  = 800,
    parameter int V_TOTAL  = 525,
    parameter int H_START  = 144,
    parameter int V_START  = 35,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int FRAMES   = 7,
    parameter int SYNC_POL = 0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          en,
    input  logic                          hsync,
    input  logic                          vsync,
    input  logic [CW-1:0]                 R,
    input  logic [CW-1:0]                 G,
    input  logic [CW-1:0]                 B,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic [23:0]                   pix_data,
    output logic [$clog2(H_ACTIVE)-1:0]   pix_x,
    output logic [$clog2(V_ACTIVE)-1:0]   pix_y,
    output logic                          pix_last,
    output logic                          frame_done,
    output logic [15:0]                   frame_cnt,
    output logic                          capture_done,
    output logic                          sync_err,
    output logic                          ovf
`ifdef VFC_CRC_EN
    ,
    output logic [15:0]                   frame_crc
`endif
);

    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int XW = $clog2(H_ACTIVE);
    localparam int YW = $clog2(V_ACTIVE);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_S    = HW'(H_START);
    localparam logic [HW-1:0] H_E    = HW'(H_START + H_ACTIVE);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_S    = VW'(V_START);
    localparam logic [VW-1:0] V_E    = VW'(V_START + V_ACTIVE);
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);
    localparam logic [15:0]   FR     = 16'(FRAMES);

    logic            hs_lead, vs_lead;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic [XW-1:0]   x_d;
    logic [YW-1:0]   y_d;
    logic            in_win, h_err, v_err;
    logic            pix_in, pix_end, load;
    rgb888_t         pix_rgb;

    vfc_state_t      state_q;
    logic            h_armed_q;
    logic [15:0]     frame_cnt_q, frame_cnt_d;
    logic            frame_done_q, capture_done_q, sync_err_q;

    logic            valid_q, last_q, ovf_q;
    logic [23:0]     data_q;
    logic [XW-1:0]   x_q;
    logic [YW-1:0]   y_q;

    vfc_sync_det #(
        .SYNC_POL (SYNC_POL)
    ) u_sync (
        .clk       (clk),
        .resetn    (resetn),
        .hsync_i   (hsync),
        .vsync_i   (vsync),
        .hs_lead_o (hs_lead),
        .vs_lead_o (vs_lead)
    );

    // current-cycle position, window decode, timing checks and slot load decision
    always_comb begin
        h_d         = hs_lead ? '0 : (h_q == H_LAST ? h_q : h_q + 1'b1);
        v_d         = vs_lead ? '0 : ((hs_lead && v_q != V_LAST) ? v_q + 1'b1 : v_q);
        x_d         = XW'(h_d - H_S);
        y_d         = YW'(v_d - V_S);
        in_win      = (h_d >= H_S) && (h_d < H_E) && (v_d >= V_S) && (v_d < V_E);
        h_err       = hs_lead && h_armed_q && (h_q != H_LAST);
        v_err       = vs_lead && (v_q != V_LAST);
        pix_in      = (state_q == CAPTURE) && en && !h_err && !v_err && in_win;
        pix_end     = pix_in && (x_d == X_LAST) && (y_d == Y_LAST);
        load        = pix_in && (!valid_q || pix_ready);
        frame_cnt_d = (pix_end && frame_cnt_q != 16'hFFFF) ? frame_cnt_q + 16'd1 : frame_cnt_q;
        pix_rgb     = '{r: expand_col(8'(R), CW), g: expand_col(8'(G), CW), b: expand_col(8'(B), CW)};
    end

    // free-running line/frame position counters, realigned by sync edges
    always_ff @(posedge clk) begin
        if (!resetn) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    // capture FSM with frame counting and sticky status flags
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q        <= WAIT_VSYNC;
            h_armed_q      <= 1'b0;
            frame_cnt_q    <= '0;
            frame_done_q   <= 1'b0;
            capture_done_q <= 1'b0;
            sync_err_q     <= 1'b0;
        end else begin
            frame_done_q <= pix_end;
            frame_cnt_q  <= frame_cnt_d;
            case (state_q)
                WAIT_VSYNC: begin
                    if (vs_lead && en) begin
                        state_q   <= CAPTURE;
                        h_armed_q <= hs_lead;
                    end
                end
                CAPTURE: begin
                    if (hs_lead)
                        h_armed_q <= 1'b1;
                    if (!en) begin
                        state_q <= WAIT_VSYNC;
                    end else if (h_err || v_err) begin
                        sync_err_q <= 1'b1;
                        state_q    <= WAIT_VSYNC;
                    end else if (pix_end && FR != 16'd0 && frame_cnt_d == FR) begin
                        capture_done_q <= 1'b1;
                        state_q        <= DONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // single-entry output slot; a pixel that finds it full and unaccepted is dropped
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (load) begin
                valid_q <= 1'b1;
                data_q  <= pix_rgb;
                x_q     <= x_d;
                y_q     <= y_d;
                last_q  <= pix_end;
            end else if (pix_ready) begin
                valid_q <= 1'b0;
            end
            if (pix_in && !load)
                ovf_q <= 1'b1;
        end
    end

`ifdef VFC_CRC_EN
    logic [15:0] crc_q, crc_d, frame_crc_q;

    // running CRC including a pixel being loaded this cycle
    always_comb crc_d = load ? crc16_upd(crc_q, pix_rgb) : crc_q;

    // CRC restarts at every frame start; the frame result is latched with frame_done
    always_ff @(posedge clk) begin
        if (!resetn) begin
            crc_q       <= CRC16_INIT;
            frame_crc_q <= '0;
        end else begin
            crc_q <= vs_lead ? CRC16_INIT : crc_d;
            if (pix_end)
                frame_crc_q <= crc_d;
        end
    end

    assign frame_crc = frame_crc_q;
`endif

    assign pix_valid    = valid_q;
    assign pix_data     = data_q;
    assign pix_x        = x_q;
    assign pix_y        = y_q;
    assign pix_last     = last_q;
    assign frame_done   = frame_done_q;
    assign frame_cnt    = frame_cnt_q;
    assign capture_done = capture_done_q;
    assign sync_err     = sync_err_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_vga_frame_capture.sv
// tb_vga_frame_capture: directed VGA timing stimulus with a pixel scoreboard
module tb_vga_frame_capture;

    localparam int CW = 4, HT = 20, VT = 12, HS = 4, VS = 2, HA = 8, VA = 6, FR = 2;

    logic          clk = 1'b0, resetn = 1'b0, en = 1'b0, hsync = 1'b1, vsync = 1'b1, pix_ready = 1'b1;
    logic [CW-1:0] R = '0, G = '0, B = '0;
    logic          pix_valid, pix_last, frame_done, capture_done, sync_err, ovf;
    logic [23:0]   pix_data;
    logic [2:0]    pix_x, pix_y;
    logic [15:0]   frame_cnt;

    always #5 clk = ~clk;

    vga_frame_capture #(
        .CW(CW), .H_TOTAL(HT), .V_TOTAL(VT), .H_START(HS), .V_START(VS),
        .H_ACTIVE(HA), .V_ACTIVE(VA), .FRAMES(FR), .SYNC_POL(0)
    ) dut (
        .clk(clk), .resetn(resetn), .en(en), .hsync(hsync), .vsync(vsync),
        .R(R), .G(G), .B(B), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
        .frame_done(frame_done), .frame_cnt(frame_cnt), .capture_done(capture_done),
        .sync_err(sync_err), .ovf(ovf)
    );

    typedef struct packed {
        logic [23:0] d;
        logic [2:0]  x;
        logic [2:0]  y;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   checks = 0, failures = 0, rx = 0, fd = 0, rx0 = 0;
    int   hpos = 0, vpos = 0, mstate = 0, mcnt = 0;
    bit   mvalid = 0, short_now = 0, err_pend = 0, fixed = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // consumer side: pop and compare every accepted pixel
    always @(negedge clk) begin
        exp_t e;
        if (frame_done) fd++;
        if (pix_valid && pix_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_pix", {31'd0, pix_valid}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("pix_data", pix_data, e.d);
                chk("pix_xy", {pix_y, pix_x}, {e.y, e.x});
                chk("pix_last", pix_last, e.last);
                rx++;
            end
        end
    end

    // one source clock: drive sync/colour, model expected capture, advance raster
    task automatic step();
        int   len = short_now ? 16 : HT;
        bit   lh = (hpos == 0);
        bit   lv = lh && (vpos == 0);
        bit   act = hpos >= HS && hpos < HS + HA && vpos >= VS && vpos < VS + VA;
        bit   serr = lh && err_pend && mstate == 1;
        int   x = hpos - HS, y = vpos - VS;
        bit   arrive, loaded, last;
        logic [3:0] r, g, b;
        r = fixed ? 4'hA : 4'(x);
        g = fixed ? 4'h5 : 4'(y);
        b = fixed ? 4'hF : 4'(hpos);
        hsync = !(hpos < 2);
        vsync = !(vpos < 2);
        R = r; G = g; B = b;
        arrive = resetn && mstate == 1 && en && !serr && act;
        last   = (x == HA - 1) && (y == VA - 1);
        loaded = arrive && !(mvalid && !pix_ready);
        if (loaded)
            q.push_back({fixed ? 24'hAA55FF : {r, r, g, g, b, b}, 3'(x), 3'(y), last});
        mvalid = resetn && (loaded || (mvalid && !pix_ready));
        if (!resetn) begin
            mstate = 0;
            mcnt   = 0;
        end else if (mstate == 0) begin
            if (lv && en) mstate = 1;
        end else if (mstate == 1) begin
            if (!en || serr) mstate = 0;
            else if (arrive && last) begin
                mcnt++;
                if (mcnt == FR) mstate = 2;
            end
        end
        if (lh) err_pend = 0;
        @(posedge clk);
        #1;
        hpos++;
        if (hpos == len) begin
            hpos      = 0;
            err_pend  = short_now;
            short_now = 0;
            vpos      = (vpos == VT - 1) ? 0 : vpos + 1;
        end
    endtask

    task automatic run_to(input int v, input int h);
        int guard = 0;
        while (!(vpos == v && hpos == h) && guard < 1000) begin
            step();
            guard++;
        end
        chk("run_to_bound", guard < 1000, 1);
    endtask

    task automatic frame();
        repeat (HT * VT) step();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, pix_valid, 0);
        chk({tag, "_data"}, pix_data, 0);
        chk({tag, "_xy_last"}, {pix_y, pix_x, pix_last}, 0);
        chk({tag, "_done"}, {frame_done, capture_done}, 0);
        chk({tag, "_cnt"}, frame_cnt, 0);
        chk({tag, "_flags"}, {sync_err, ovf}, 0);
    endtask

    task automatic do_reset();
        resetn = 1'b0; hsync = 1'b1; vsync = 1'b1;
        mstate = 0; mcnt = 0; mvalid = 0; err_pend = 0; short_now = 0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        hpos = 0; vpos = 0;
    endtask

    initial begin
        // full capture of FRAMES frames, then idle
        do_reset();
        chk_zero("reset");
        en = 1'b1; pix_ready = 1'b1; fixed = 0;
        frame();
        chk("f0_pixels", rx, 48);
        chk("f0_cnt", frame_cnt, 1);
        chk("f0_done_pulses", fd, 1);
        chk("f0_cap_done", capture_done, 0);
        fixed = 1;
        frame();
        chk("f1_pixels", rx, 96);
        chk("f1_cnt", frame_cnt, 2);
        chk("f1_cap_done", capture_done, 1);
        fixed = 0;
        frame();
        chk("after_done_pixels", rx, 96);
        chk("after_done_cnt", frame_cnt, 2);
        chk("after_done_pulses", fd, 2);

        // consumer stall mid-line
        do_reset();
        rx0 = rx;
        run_to(4, 6);
        step();
        pix_ready = 1'b0;
        repeat (3) begin
            step();
            chk("stall_valid", pix_valid, 1);
            chk("stall_x", pix_x, 2);
        end
        pix_ready = 1'b1;
        run_to(0, 0);
        chk("stall_ovf", ovf, 1);
        chk("stall_pixels", rx - rx0, 45);
        chk("stall_cnt", frame_cnt, 1);
        chk("stall_sync_err", sync_err, 0);

        // short line inside a captured frame
        run_to(4, 0);
        short_now = 1;
        run_to(5, 3);
        chk("short_sync_err", sync_err, 1);
        chk("short_cnt", frame_cnt, 1);
        run_to(0, 0);
        chk("short_cnt_end", frame_cnt, 1);
        frame();
        chk("relock_cnt", frame_cnt, 2);
        chk("relock_cap_done", capture_done, 1);
        chk("relock_sync_err", sync_err, 1);

        // enable dropped mid-frame
        do_reset();
        rx0 = rx;
        run_to(3, 5);
        en = 1'b0;
        repeat (4) step();
        en = 1'b1;
        run_to(0, 0);
        chk("en_drop_pixels", rx - rx0, 9);
        chk("en_drop_cnt", frame_cnt, 0);
        frame();
        chk("en_full_pixels", rx - rx0, 57);
        chk("en_full_cnt", frame_cnt, 1);

        // reset at pixel (3,2) of a captured frame
        rx0 = rx;
        run_to(4, 7);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk_zero("midrst");
        chk("midrst_pixels", rx - rx0, 19);
        run_to(0, 0);
        rx0 = rx;
        frame();
        chk("restart_pixels", rx - rx0, 48);
        chk("restart_cnt", frame_cnt, 1);
        chk("restart_cap_done", capture_done, 0);
        chk("queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
